// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM: sequences fetch/decode/execute/writeback and counts retired instructions.
// Latency: one state per cycle; outputs are Moore from state, with FETCH/MEMWRITE/BEQ gated by mem_ready/zero.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until mem_ready=1; mem_ready is ignored elsewhere.
// Optional feature: define ILLEGAL_TRAP_EN to trap unknown opcodes into HALT with a sticky illegal flag.
module multicycle_ctrl #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          op,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                adr_src,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic [1:0]          result_src,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                retire,
  output logic [RETIRE_W-1:0] instret,
  output logic                illegal
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [RETIRE_W-1:0] r_instret;

  // State register; reset abandons any in-flight access by returning to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and control outputs; outputs depend only on state plus mem_ready/zero, never on op.
  always_comb begin
    w_next     = r_state;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    retire     = 1'b0;
    case (r_state)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_BEQ:            w_next = S_BEQ;
          OP_JAL:            w_next = S_JAL;
`ifdef ILLEGAL_TRAP_EN
          default:           w_next = S_HALT;
`else
          // Unknown opcode is skipped: refetch without retiring.
          default:           w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        w_next    = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        retire    = mem_ready;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        w_next    = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        w_next    = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = zero;
        retire    = 1'b1;
        w_next    = S_FETCH;
      end
      S_JAL: begin
        // Link value is written back in ALUWB, which also retires the jump.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        w_next    = S_ALUWB;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Retired-instruction counter; wraps naturally at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= '0;
    end else if (retire) begin
      r_instret <= r_instret + RETIRE_W'(1);
    end
  end

  assign instret = r_instret;

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;

  // Sticky flag set when DECODE traps into HALT; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
    end else if (r_state == S_DECODE && w_next == S_HALT) begin
      r_illegal <= 1'b1;
    end
  end

  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction cycle plans checked against expected control vectors.
// Uses a narrow retire counter so wrap-around is reachable quickly.
// Handles both builds of the illegal-opcode trap option.
module tb_multicycle_ctrl;

  localparam int TW = 4;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BQ  = 7'b1100011;
  localparam logic [6:0] OP_JL  = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // Phase identifiers used by the reference plans (names only, for messages).
  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3, P_MEMWB = 4,
                 P_MEMWRITE = 5, P_EXECR = 6, P_EXECI = 7, P_ALUWB = 8, P_BEQ = 9,
                 P_JAL = 10, P_HALT = 11;

  logic          clk;
  logic          rst_n;
  logic [6:0]    op;
  logic          zero;
  logic          mem_ready;
  logic          pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0]    result_src, alu_src_a, alu_src_b, alu_op;
  logic          retire;
  logic [TW-1:0] instret;
  logic          illegal;

  int            n_vec;
  int            n_bad;
  logic [TW-1:0] exp_cnt;
  logic          exp_ill;

  multicycle_ctrl #(.RETIRE_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .retire(retire), .instret(instret),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control word for a phase, straight from the per-state output table.
  // Packing: {pc_write,adr_src,mem_write,ir_write,reg_write,result_src,alu_src_a,alu_src_b,alu_op,retire}
  function automatic logic [13:0] exp_vec(int ph, logic mr, logic z);
    logic pcw, adr, mw, irw, rw, ret;
    logic [1:0] rs, sa, sb, ao;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ret = 0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; ao = 2'b00;
    case (ph)
      P_FETCH:    begin sb = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
      P_DECODE:   begin sa = 2'b01; sb = 2'b01; end
      P_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
      P_MEMREAD:  begin adr = 1; end
      P_MEMWB:    begin rs = 2'b01; rw = 1; ret = 1; end
      P_MEMWRITE: begin adr = 1; mw = 1; ret = mr; end
      P_EXECR:    begin sa = 2'b10; ao = 2'b10; end
      P_EXECI:    begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
      P_ALUWB:    begin rw = 1; ret = 1; end
      P_BEQ:      begin sa = 2'b10; ao = 2'b01; pcw = z; ret = 1; end
      P_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      default:    begin end
    endcase
    return {pcw, adr, mw, irw, rw, rs, sa, sb, ao, ret};
  endfunction

  // One clock of a plan: drive at posedge+1, check at negedge, advance model.
  task automatic cyc(input int ph, input logic mr, input logic z);
    logic [13:0] e, g;
    mem_ready = mr;
    zero      = z;
    @(negedge clk);
    e = exp_vec(ph, mr, z);
    g = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
         alu_src_a, alu_src_b, alu_op, retire};
    n_vec++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL ctl phase=%0d t=%0t got=%h want=%h", ph, $time, g, e);
    end
    n_vec++;
    if (instret !== exp_cnt) begin
      n_bad++;
      $display("FAIL instret phase=%0d t=%0t got=%0d want=%0d", ph, $time, instret, exp_cnt);
    end
    n_vec++;
    if (illegal !== exp_ill) begin
      n_bad++;
      $display("FAIL illegal phase=%0d t=%0t got=%b want=%b", ph, $time, illegal, exp_ill);
    end
    if (e[0]) exp_cnt = exp_cnt + 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Reference plan for one instruction: fetch waits, decode, then the class-specific path.
  task automatic run_instr(input logic [6:0] o, input logic z, input int fw, input int mw);
    op = o;
    for (int i = 0; i < fw; i++) cyc(P_FETCH, 1'b0, rnd_bit());
    cyc(P_FETCH, 1'b1, rnd_bit());
    cyc(P_DECODE, rnd_bit(), rnd_bit());
    case (o)
      OP_LW: begin
        cyc(P_MEMADR, rnd_bit(), rnd_bit());
        for (int i = 0; i < mw; i++) cyc(P_MEMREAD, 1'b0, rnd_bit());
        cyc(P_MEMREAD, 1'b1, rnd_bit());
        cyc(P_MEMWB, rnd_bit(), rnd_bit());
      end
      OP_SW: begin
        cyc(P_MEMADR, rnd_bit(), rnd_bit());
        for (int i = 0; i < mw; i++) cyc(P_MEMWRITE, 1'b0, rnd_bit());
        cyc(P_MEMWRITE, 1'b1, rnd_bit());
      end
      OP_R:  begin cyc(P_EXECR, rnd_bit(), rnd_bit()); cyc(P_ALUWB, rnd_bit(), rnd_bit()); end
      OP_I:  begin cyc(P_EXECI, rnd_bit(), rnd_bit()); cyc(P_ALUWB, rnd_bit(), rnd_bit()); end
      OP_BQ: cyc(P_BEQ, rnd_bit(), z);
      OP_JL: begin cyc(P_JAL, rnd_bit(), rnd_bit()); cyc(P_ALUWB, rnd_bit(), rnd_bit()); end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        exp_ill = 1'b1;
        for (int i = 0; i < 3; i++) cyc(P_HALT, rnd_bit(), rnd_bit());
`endif
      end
    endcase
  endtask

  // Pulse reset at posedge+1 and check the asynchronous effect before any edge.
  task automatic do_reset(input logic mr);
    logic [13:0] g, e;
    mem_ready = mr;
    rst_n = 1'b0;
    #1;
    exp_cnt = '0;
    exp_ill = 1'b0;
    e = exp_vec(P_FETCH, mr, 1'b0);
    g = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
         alu_src_a, alu_src_b, alu_op, retire};
    n_vec++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL reset_ctl got=%h want=%h", g, e);
    end
    n_vec++;
    if (instret !== exp_cnt) begin
      n_bad++;
      $display("FAIL reset_instret got=%0d want=0", instret);
    end
    n_vec++;
    if (illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_illegal got=%b want=0", illegal);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    do_reset(1'b1);
    do_reset(1'b0);
  endtask

  task automatic test_rtype();
    run_instr(OP_R, 1'b0, 0, 0);
    run_instr(OP_I, 1'b1, 1, 0);
  endtask

  task automatic test_load_wait();
    run_instr(OP_LW, 1'b0, 0, 3);
    run_instr(OP_SW, 1'b0, 2, 2);
  endtask

  task automatic test_beq();
    run_instr(OP_BQ, 1'b1, 0, 0);
    run_instr(OP_BQ, 1'b0, 0, 0);
  endtask

  task automatic test_jal();
    run_instr(OP_JL, 1'b0, 0, 0);
  endtask

  // Store abandoned by reset while waiting on memory: mem_write must drop at once.
  task automatic test_reset_mid_store();
    op = OP_SW;
    cyc(P_FETCH, 1'b1, 1'b0);
    cyc(P_DECODE, 1'b0, 1'b0);
    cyc(P_MEMADR, 1'b0, 1'b0);
    cyc(P_MEMWRITE, 1'b0, 1'b0);
    cyc(P_MEMWRITE, 1'b0, 1'b0);
    do_reset(1'b0);
    run_instr(OP_R, 1'b0, 0, 0);
  endtask

  task automatic test_illegal();
    run_instr(OP_BAD, 1'b0, 0, 0);
`ifdef ILLEGAL_TRAP_EN
    do_reset(1'b0);
`endif
    run_instr(OP_LW, 1'b0, 0, 0);
  endtask

  // Drive the counter to all-ones, then one more retirement must wrap it to zero.
  task automatic test_wrap();
    @(posedge clk);
    #1;
    do_reset(1'b0);
    for (int i = 0; i < (1 << TW) - 1; i++) run_instr(OP_R, 1'b0, 0, 0);
    n_vec++;
    if (instret !== {TW{1'b1}}) begin
      n_bad++;
      $display("FAIL wrap_pre got=%0d want=%0d", instret, {TW{1'b1}});
    end
    run_instr(OP_R, 1'b0, 0, 0);
    n_vec++;
    if (instret !== '0) begin
      n_bad++;
      $display("FAIL wrap_post got=%0d want=0", instret);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [7];
    int nops;
    ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_R; ops[3] = OP_I;
    ops[4] = OP_BQ; ops[5] = OP_JL; ops[6] = OP_BAD;
`ifdef ILLEGAL_TRAP_EN
    nops = 6;
`else
    nops = 7;
`endif
    for (int k = 0; k < 80; k++) begin
      run_instr(ops[$urandom_range(0, nops - 1)], rnd_bit(),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    exp_cnt   = '0;
    exp_ill   = 1'b0;
    rst_n     = 1'b0;
    op        = OP_R;
    zero      = 1'b0;
    mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_load_wait();
    test_beq();
    test_jal();
    test_reset_mid_store();
    test_illegal();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
